// File: rtl/gcttt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gcttt_pkg
// Brief   : Shared types and constants for the IPU interrupt controller.
// Revision: 1.0 - initial release
// ============================================================================
package gcttt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam int                 COORD_W  = 4;
    localparam logic [COORD_W-1:0] MAX_CELL = 4'd8;

endpackage
`default_nettype wire

// File: rtl/coord_fifo.sv
`default_nettype none
// ============================================================================
// Module  : coord_fifo
// Brief   : DEPTH x WIDTH synchronous FIFO with push/pop and occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
module coord_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    // Caller guarantees push only when not full and pop only when not empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/ipu_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ipu_int_ctrl
// Brief   : Buffers IPU grid events and issues them one at a time to the core
//           as acknowledged interrupts with timeout/retry.
// Revision: 1.0 - initial release
// ============================================================================
module ipu_int_ctrl
    import gcttt_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 64,
    parameter int ACK_TIMEOUT = 256,
    parameter int MAX_RETRY   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     evt_valid,
    input  logic [COORD_W-1:0]       evt_coord,
    output logic                     evt_ready,
    input  logic                     int_ack,
    input  logic                     proc_halt,
    input  logic                     clr_err,
    output logic                     ipu_int,
    output logic [COORD_W-1:0]       grid_coord,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     err_bad_coord,
    output logic                     err_timeout
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int TO_W    = $clog2(ACK_TIMEOUT) + 1;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;

    state_e               state_q,      state_d;
    logic                 ipu_int_q,    ipu_int_d;
    logic [COORD_W-1:0]   grid_coord_q, grid_coord_d;
    logic [TO_W-1:0]      to_cnt_q,     to_cnt_d;
    logic [HOLD_W-1:0]    hold_cnt_q,   hold_cnt_d;
    logic [RETRY_W-1:0]   retry_q,      retry_d;
    logic                 err_bad_q,    err_bad_d;
    logic                 err_to_q,     err_to_d;

    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 timeout_drop;
    logic [COORD_W-1:0]   head;
    logic [CNT_W-1:0]     count;

    // Ready comes from registered occupancy only, so a full FIFO stalls even on a pop cycle.
    assign evt_ready = (count != CNT_W'(DEPTH));
    assign accept    = evt_valid & evt_ready;
    assign push      = accept & (evt_coord <= MAX_CELL);
    assign pop       = (state_q == IDLE) & (count != '0) & ~proc_halt;

    coord_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (COORD_W)
    ) u_coord_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (evt_coord),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        state_d      = state_q;
        grid_coord_d = grid_coord_q;
        to_cnt_d     = to_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        retry_d      = retry_q;
        timeout_drop = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    grid_coord_d = head;
                    to_cnt_d     = '0;
                    retry_d      = '0;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end else if (to_cnt_q >= TO_W'(ACK_TIMEOUT - 1)) begin
                    if (retry_q != '1) begin
                        retry_d = retry_q + RETRY_W'(1);
                    end
                    state_d = GAP;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            GAP: begin
                if (retry_q > RETRY_W'(MAX_RETRY)) begin
                    timeout_drop = 1'b1;
                    state_d      = IDLE;
                end else begin
                    to_cnt_d = '0;
                    state_d  = REQ;
                end
            end
            HOLD: begin
                if (hold_cnt_q >= HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ipu_int_d = (state_d == REQ);
        // Set beats a same-cycle clear.
        err_bad_d = (accept & (evt_coord > MAX_CELL)) | (err_bad_q & ~clr_err);
        err_to_d  = timeout_drop | (err_to_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ipu_int_q    <= 1'b0;
            grid_coord_q <= '0;
            to_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            retry_q      <= '0;
            err_bad_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ipu_int_q    <= ipu_int_d;
            grid_coord_q <= grid_coord_d;
            to_cnt_q     <= to_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            retry_q      <= retry_d;
            err_bad_q    <= err_bad_d;
            err_to_q     <= err_to_d;
        end
    end

    assign ipu_int       = ipu_int_q;
    assign grid_coord    = grid_coord_q;
    assign pending       = count;
    assign err_bad_coord = err_bad_q;
    assign err_timeout   = err_to_q;

endmodule
`default_nettype wire
